// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory req/ack port plus the valid/ready stream to decode.
interface fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, runs req/ack transactions to instruction
// memory, buffers returned words in a prefetch FIFO and streams them to decode.
module fetch_unit #(
    parameter int          ADDR_W   = 16,
    parameter int          INSTR_W  = 16,
    parameter int          DEPTH    = 4,
    parameter int          PC_STEP  = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fetch_unit_if.master               bus,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       hlt,
    output logic [ADDR_W-1:0]          pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    state_t             state, state_d;
    logic [ADDR_W-1:0]  drop_addr;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               req, push, pop, has_space, instr_valid;
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];

    assign has_space   = count < CNT_W'(DEPTH);
    assign instr_valid = count != '0;
    // A redirect flushes the FIFO, so a same-cycle pop must not move the read pointer.
    assign pop         = instr_valid && bus.instr_ready && !redirect;

    always_comb begin
        req     = 1'b0;
        push    = 1'b0;
        state_d = state;
        case (state)
            IDLE: begin
                req = rst_n && !hlt && !redirect && has_space;
                if (req) begin
                    if (bus.imem_ack) push = 1'b1;
                    else              state_d = BUSY;
                end
            end
            BUSY: begin
                req = 1'b1;
                if (bus.imem_ack) begin
                    state_d = IDLE;
                    push    = !redirect;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                req = 1'b1;
                if (bus.imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = (state == DROP) ? drop_addr : pc;
    assign bus.instr_valid = instr_valid;
    assign bus.instr       = instr_mem[rd_ptr];
    assign bus.instr_pc    = pc_mem[rd_ptr];
    assign occupancy       = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= ADDR_W'(RESET_PC);
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_d;
            if (redirect)  pc <= redirect_pc;
            else if (push) pc <= pc + ADDR_W'(PC_STEP);

            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (!push && pop) count <= count - CNT_W'(1);
            end
        end
    end

    // Abandoned request keeps its address on the bus until the memory acks it.
    always_ff @(posedge clk) begin
        if (state == BUSY && redirect && !bus.imem_ack) drop_addr <= pc;
        if (push) begin
            instr_mem[wr_ptr] <= bus.imem_rdata;
            pc_mem[wr_ptr]    <= pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: table-driven streaming/backpressure vectors, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_fetch_unit;
    localparam int AW    = 16;
    localparam int IW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          redirect = 1'b0;
    logic          hlt = 1'b0;
    logic          ready = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [AW-1:0] pc, pc_w;
    logic [2:0]    occ, occ_w;
    int            lat = 0;
    int            wait_cnt = 0;
    logic          rand_mode = 1'b0;
    logic          rand_ack = 1'b0;
    logic          force_ack = 1'b0;
    int            errors = 0;
    int            checks = 0;

    fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();
    fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus_w ();

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .PC_STEP(2), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .redirect(redirect), .redirect_pc(redirect_pc),
        .hlt(hlt), .pc(pc), .occupancy(occ));

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .PC_STEP(2), .RESET_PC(32'hFFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(bus_w), .redirect(1'b0), .redirect_pc(16'h0000),
        .hlt(1'b0), .pc(pc_w), .occupancy(occ_w));

    always #5 clk = ~clk;

    // Memory model: fixed latency (lat wait cycles) or random ack; data is address ^ A5A5.
    assign bus.imem_ack    = force_ack | (bus.imem_req & (rand_mode ? rand_ack : (wait_cnt >= lat)));
    assign bus.imem_rdata  = bus.imem_addr ^ 16'hA5A5;
    assign bus.instr_ready = ready;
    assign bus_w.imem_ack    = bus_w.imem_req;
    assign bus_w.imem_rdata  = bus_w.imem_addr ^ 16'hA5A5;
    assign bus_w.instr_ready = 1'b1;

    always @(posedge clk) wait_cnt <= (bus.imem_req && !bus.imem_ack) ? wait_cnt + 1 : 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; redirect = 1'b0; hlt = 1'b0; force_ack = 1'b0; rand_mode = 1'b0;
        #1;
        chk1("rst_req", bus.imem_req, 1'b0);
        chk1("rst_req_w", bus_w.imem_req, 1'b0);
        chk1("rst_valid", bus.instr_valid, 1'b0);
        chk16("rst_occ", 16'(occ), 16'h0);
        chk16("rst_pc", pc, 16'h0000);
        chk16("rst_pc_w", pc_w, 16'hFFFC);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          rst;
        logic          rdy;
        logic          req;
        logic [15:0]   addr;
        logic          vld;
        logic [15:0]   ipc;
        logic [2:0]    occ;
        logic [15:0]   pcv;
    } vec_t;

    vec_t tbl [15];

    logic [15:0] m_pc, m_addr, cur_addr, e16;
    logic        m_out, m_drop, m_req, fire, pop;
    logic [15:0] mq [$];
    logic        found;

    initial begin
        // Streaming (ready=1) then backpressure (ready=0, released later), zero-wait memory.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 3'd0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000, 3'd1, 16'h0002};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 3'd1, 16'h0004};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004, 3'd1, 16'h0006};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'h0008, 1'b1, 16'h0006, 3'd1, 16'h0008};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 3'd0, 16'h0000};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000, 3'd1, 16'h0002};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 1'b1, 16'h0000, 3'd2, 16'h0004};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h0006, 1'b1, 16'h0000, 3'd3, 16'h0006};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 3'd4, 16'h0008};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 3'd4, 16'h0008};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 16'h0008, 1'b1, 16'h0002, 3'd3, 16'h0008};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 16'h000A, 1'b1, 16'h0004, 3'd3, 16'h000A};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 16'h000C, 1'b1, 16'h0006, 3'd3, 16'h000C};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 16'h000E, 1'b1, 16'h0008, 3'd3, 16'h000E};

        lat = 0;
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].rst) do_reset();
            ready = tbl[i].rdy;
            #1;
            chk1("tbl_req", bus.imem_req, tbl[i].req);
            if (tbl[i].req) chk16("tbl_addr", bus.imem_addr, tbl[i].addr);
            chk1("tbl_valid", bus.instr_valid, tbl[i].vld);
            if (tbl[i].vld) begin
                chk16("tbl_ipc", bus.instr_pc, tbl[i].ipc);
                chk16("tbl_instr", bus.instr, tbl[i].ipc ^ 16'hA5A5);
            end
            chk16("tbl_occ", 16'(occ), 16'(tbl[i].occ));
            chk16("tbl_pc", pc, tbl[i].pcv);
            @(negedge clk);
        end

        // Wrap-around from RESET_PC=FFFC on the second instance.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            e16 = 16'hFFFC + 16'(2 * i);
            if (i < 4) chk16("wrap_addr", bus_w.imem_addr, e16);
            if (i > 0) chk16("wrap_ipc", bus_w.instr_pc, e16 - 16'd2);
            @(negedge clk);
        end

        // Redirect while the request to 0x0006 is outstanding (3-cycle memory).
        ready = 1'b0; lat = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            #1;
            if (bus.imem_req && bus.imem_addr == 16'h0006) found = 1'b1;
            else @(negedge clk);
        end
        chk1("redir_found_req6", found, 1'b1);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0100;
        #1;
        chk1("redir_req_hold", bus.imem_req, 1'b1);
        chk16("redir_addr_hold", bus.imem_addr, 16'h0006);
        chk16("redir_occ_before", 16'(occ), 16'd3);
        @(negedge clk);
        redirect = 1'b0; ready = 1'b1;
        #1;
        chk1("redir_valid_flushed", bus.instr_valid, 1'b0);
        chk16("redir_occ_flushed", 16'(occ), 16'd0);
        chk16("redir_pc", pc, 16'h0100);
        chk16("redir_drop_addr", bus.imem_addr, 16'h0006);
        @(negedge clk);
        #1;
        chk1("redir_new_req", bus.imem_req, 1'b1);
        chk16("redir_new_addr", bus.imem_addr, 16'h0100);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            #1;
            if (bus.instr_valid) found = 1'b1;
        end
        chk1("redir_valid_seen", found, 1'b1);
        chk16("redir_first_ipc", bus.instr_pc, 16'h0100);
        chk16("redir_first_instr", bus.instr, 16'h0100 ^ 16'hA5A5);

        // Halt raised while a 2-cycle request is outstanding.
        ready = 1'b0; lat = 1;
        do_reset();
        #1; chk16("hlt_addr0", bus.imem_addr, 16'h0000); chk1("hlt_req0", bus.imem_req, 1'b1);
        @(negedge clk); hlt = 1'b1;
        #1; chk1("hlt_req_held", bus.imem_req, 1'b1); chk16("hlt_addr_held", bus.imem_addr, 16'h0000);
        @(negedge clk);
        #1; chk1("hlt_no_req", bus.imem_req, 1'b0); chk16("hlt_occ1", 16'(occ), 16'd1);
        chk16("hlt_pc", pc, 16'h0002);
        @(negedge clk); ready = 1'b1;
        #1; chk1("hlt_no_req2", bus.imem_req, 1'b0);
        @(negedge clk);
        #1; chk1("hlt_drained", bus.instr_valid, 1'b0); chk1("hlt_no_req3", bus.imem_req, 1'b0);
        @(negedge clk); hlt = 1'b0;
        #1; chk1("hlt_resume_req", bus.imem_req, 1'b1); chk16("hlt_resume_addr", bus.imem_addr, 16'h0002);

        // Reset asserted mid-transaction with two entries buffered, then a late ack.
        ready = 1'b0; lat = 0;
        do_reset();
        @(negedge clk);
        @(negedge clk); lat = 5;
        #1; chk1("mrst_req", bus.imem_req, 1'b1); chk16("mrst_occ", 16'(occ), 16'd2);
        chk16("mrst_addr", bus.imem_addr, 16'h0004);
        @(negedge clk);
        #2; rst_n = 1'b0; force_ack = 1'b1;
        #1; chk1("mrst_req_low", bus.imem_req, 1'b0); chk1("mrst_valid_low", bus.instr_valid, 1'b0);
        chk16("mrst_occ0", 16'(occ), 16'd0); chk16("mrst_pc0", pc, 16'h0000);
        @(negedge clk);
        #1; chk16("mrst_late_ack_occ", 16'(occ), 16'd0);
        @(negedge clk); rst_n = 1'b1; force_ack = 1'b0; lat = 0;
        #1; chk16("mrst_rel_pc", pc, 16'h0000); chk1("mrst_rel_valid", bus.instr_valid, 1'b0);
        chk16("mrst_rel_addr", bus.imem_addr, 16'h0000);
        @(negedge clk);
        #1; chk1("mrst_rel_valid1", bus.instr_valid, 1'b1); chk16("mrst_rel_ipc", bus.instr_pc, 16'h0000);

        // Randomized run against a queue model of the fetch behaviour.
        do_reset();
        rand_mode = 1'b1;
        m_pc = 16'h0000; m_addr = 16'h0000; m_out = 1'b0; m_drop = 1'b0; mq.delete();
        for (int n = 0; n < 3000; n++) begin
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = 16'($urandom) & 16'hFFFE;
            hlt         = ($urandom_range(0, 4) == 0);
            ready       = ($urandom_range(0, 2) != 0);
            rand_ack    = ($urandom_range(0, 1) == 1);
            #1;
            m_req    = m_out || (!hlt && !redirect && mq.size() < DEPTH);
            cur_addr = m_drop ? m_addr : m_pc;
            chk1("rnd_req", bus.imem_req, m_req);
            if (m_req) chk16("rnd_addr", bus.imem_addr, cur_addr);
            chk1("rnd_valid", bus.instr_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk16("rnd_ipc", bus.instr_pc, mq[0]);
                chk16("rnd_instr", bus.instr, mq[0] ^ 16'hA5A5);
            end
            chk16("rnd_occ", 16'(occ), 16'(mq.size()));
            chk16("rnd_pc", pc, m_pc);
            fire = m_req && rand_ack;
            pop  = (mq.size() != 0) && ready && !redirect;
            if (redirect) begin
                mq.delete();
                if (m_req && !fire) begin
                    m_out = 1'b1; m_drop = 1'b1; m_addr = cur_addr;
                end else begin
                    m_out = 1'b0; m_drop = 1'b0;
                end
                m_pc = redirect_pc;
            end else begin
                if (pop) void'(mq.pop_front());
                if (fire) begin
                    if (!m_drop) begin
                        mq.push_back(m_pc);
                        m_pc = m_pc + 16'd2;
                    end
                    m_out = 1'b0; m_drop = 1'b0;
                end else if (m_req) begin
                    m_out = 1'b1;
                end
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation core. It replaces the single-cycle PC-plus-combinational-instruction-memory arrangement with a fetch stage that:
- owns the fetch PC,
- talks to a variable-latency instruction memory over a req/ack handshake,
- buffers fetched words in a prefetch FIFO,
- presents them to decode over a valid/ready interface.
Branch/jump resolution downstream redirects it, and the halt decode stops further fetching.

Parameters:
ADDR_W, 16, width of PC and instruction address
INSTR_W, 16, instruction word width
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
PC_STEP, 2, byte increment per sequential fetch
RESET_PC, 0, fetch address after reset

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  request address
imem_ack  input  1  memory returns data this cycle (valid only while imem_req=1)
imem_rdata  input  INSTR_W  instruction data, sampled when imem_req&imem_ack
redirect  input  1  flush and restart fetch (taken branch / jump)
redirect_pc  input  ADDR_W  new fetch address, sampled when redirect=1
hlt  input  1  level; while high no new fetch transaction starts
instr_valid  output  1  FIFO head valid
instr  output  INSTR_W  FIFO head instruction
instr_pc  output  ADDR_W  address of FIFO head instruction
instr_ready  input  1  decode accepts head (pop when valid&ready)
pc  output  ADDR_W  current fetch PC (address of next/outstanding request)
occupancy  output  $clog2(DEPTH+1)  FIFO entry count

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, FIFO empty, occupancy=0, instr_valid=0, FSM=IDLE. imem_req forced 0 while rst_n=0. instr and instr_pc are don't-care when invalid.
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY: transaction outstanding, result kept.
  - DROP: transaction outstanding, result discarded.
- imem_req=1 in BUSY and DROP. In IDLE, imem_req = !hlt && !redirect && occupancy<DEPTH. This is combinational, so a zero-wait memory can ack in the same cycle.
- imem_addr=pc in IDLE/BUSY. In DROP it holds the address of the abandoned request.
- Transaction rules:
  - A transaction is any cycle with imem_req=1; it completes on imem_ack=1.
  - Once imem_req is high, it and imem_addr are held stable until ack regardless of hlt, redirect or FIFO state.
  - IDLE/BUSY with req&ack and no redirect: push {imem_rdata, pc}; pc <= pc+PC_STEP, modulo 2^ADDR_W (wraps); FSM=IDLE.
  - IDLE with req&!ack: FSM=BUSY.
- Space guarantee: a transaction starts only when occupancy<DEPTH. Pops only lower occupancy, so a push can never overflow. Simultaneous push and pop leaves occupancy unchanged.
- Throughput: zero-wait memory with instr_ready=1 gives one instruction per cycle.
- Latency: ack cycle -> instr_valid on the next cycle. There is no bypass.
- Redirect (highest priority, any state):
  - FIFO flushed: occupancy=0, instr_valid=0 on the next cycle. A pop in the same cycle is ignored.
  - pc <= redirect_pc.
  - If a transaction is outstanding and not acked this cycle: FSM=DROP. If acked this cycle: data discarded, FSM=IDLE.
  - Redirect in DROP: pc updated again, stay DROP.
- DROP: on ack, data discarded, FSM=IDLE. Fetch then resumes at pc under the normal IDLE rule.
- hlt: blocks only new transactions. An outstanding transaction completes and pushes normally. The FIFO keeps draining. Redirect is still honoured.
- Reset mid-transaction: everything returns to reset values immediately; a late ack is ignored because imem_req=0.
- Output ordering: instr_valid = occupancy!=0; instr/instr_pc come from the FIFO head, in fetch order.

Test Plan:
1. Reset + streaming: zero-wait memory, imem_rdata=imem_addr^16'hA5A5, ready=1. Expect imem_req=0 during reset, first instr_valid 1 cycle after first ack. instr_pc=0,2,4,6 consecutively, instr=A5A5,A5A7,A5A1,A5A3.
2. Backpressure: ready=0, DEPTH=4. Expect exactly 4 acks, then imem_req=0, occupancy=4, pc=8. Raise ready: pops pcs 0,2,4,6 in order; fetching resumes at addr 8.
3. Redirect mid-transaction: 3-cycle ack latency; redirect to 0x0100 one cycle after the req to 0x0006 starts. Expect req held at 0x0006 until ack, that data never output, instr_valid=0 the cycle after redirect, next req addr 0x0100.
4. Wrap: RESET_PC=0xFFFC. Expect request addresses FFFC, FFFE, 0000, 0002 and matching instr_pc.
5. Halt: assert hlt during an outstanding 2-cycle request. Expect it to complete and push, no new req while hlt=1, occupancy drained by ready. Deassert hlt: next req at the following pc.
6. Reset mid-operation: rst_n low while req outstanding and occupancy=2. Expect imem_req=0 and instr_valid=0 immediately. After release: pc=RESET_PC, a late ack is ignored.
